// File: rtl/join_adder_out_buffer.sv
// Two-entry in-order output buffer. The upstream ready is a register so that
// no combinational path runs from out_ready back to the producer.
module join_adder_out_buffer #(
  parameter int data_width = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data
);

  logic [data_width-1:0] mem [0:1];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  push;
  logic                  pop;

  assign push      = in_valid & in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // Occupancy, pointers and the registered upstream ready.
  // in_ready is out_ready delayed by one edge; whenever it is 1 the previous
  // edge popped any pending entry, so occupancy is at most 1 and a push
  // arriving just as out_ready falls still fits in the second slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      in_ready <= out_ready;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/a_plus_b_join_adder.sv
// Join stage: pairs operand streams A and B in arrival order and emits their
// zero-extended sum through a registered two-entry output buffer.
module a_plus_b_join_adder #(
  parameter int width = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [width-1:0] a_data,
  input  logic           b_valid,
  output logic           b_ready,
  input  logic [width-1:0] b_data,
  output logic           sum_valid,
  input  logic           sum_ready,
  output logic [width:0] sum_data
);

  localparam int sum_width = width + 1;

  logic [width-1:0]     a_hold_data;
  logic [width-1:0]     b_hold_data;
  logic                 a_hold_valid;
  logic                 b_hold_valid;
  logic                 buf_in_ready;
  logic                 fire;
  logic [sum_width-1:0] sum;

  assign fire    = a_hold_valid & b_hold_valid & buf_in_ready;
  assign a_ready = ~a_hold_valid | fire;
  assign b_ready = ~b_hold_valid | fire;
  assign sum     = {1'b0, a_hold_data} + {1'b0, b_hold_data};

  // Hold-register occupancy: refill on accept, drain on fire otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold_valid <= 1'b0;
      b_hold_valid <= 1'b0;
    end else begin
      if (a_valid && a_ready) a_hold_valid <= 1'b1;
      else if (fire)          a_hold_valid <= 1'b0;
      if (b_valid && b_ready) b_hold_valid <= 1'b1;
      else if (fire)          b_hold_valid <= 1'b0;
    end
  end

  // Operand capture; data is qualified by the valid bits, so no reset.
  always_ff @(posedge clk) begin
    if (a_valid && a_ready) a_hold_data <= a_data;
    if (b_valid && b_ready) b_hold_data <= b_data;
  end

  join_adder_out_buffer #(
    .data_width (sum_width)
  ) u_out_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fire),
    .in_ready  (buf_in_ready),
    .in_data   (sum),
    .out_valid (sum_valid),
    .out_ready (sum_ready),
    .out_data  (sum_data)
  );

endmodule

// File: tb/tb_a_plus_b_join_adder.sv
// Self-checking bench for a_plus_b_join_adder: directed scenarios plus a
// randomized stream compared against an in-order pairing model.
module tb_a_plus_b_join_adder;

  localparam int W      = 8;
  localparam int LOGLEN = 1024;

  logic         clk;
  logic         rst_n;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;
  logic         sum_valid;
  logic         sum_ready;
  logic [W:0]   sum_data;

  int checks = 0;
  int errors = 0;

  // Source data for streamed tests.
  int src_a [0:63];
  int src_b [0:63];

  // Observed transfers (recorded at negedge, transfer happens on next posedge).
  int         acc_a_q [$];
  int         acc_b_q [$];
  logic [W:0] out_q   [$];

  // Per-cycle log written by run_stream.
  logic       log_sv [0:LOGLEN-1];
  logic [W:0] log_sd [0:LOGLEN-1];
  logic       log_ar [0:LOGLEN-1];
  logic       log_br [0:LOGLEN-1];

  a_plus_b_join_adder #(
    .width (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid && a_ready)     acc_a_q.push_back(int'(a_data));
      if (b_valid && b_ready)     acc_b_q.push_back(int'(b_data));
      if (sum_valid && sum_ready) out_q.push_back(sum_data);
    end
  end

  task automatic clear_queues();
    acc_a_q.delete();
    acc_b_q.delete();
    out_q.delete();
  endtask

  // Drives n elements of src_a/src_b with hold-until-accepted valids.
  // Called at posedge+1 with the DUT idle; returns at posedge+1.
  task automatic run_stream(input int n, input bit rnd, input int stall_lo,
                            input int stall_hi, output int cycles, output bit timed_out);
    int ai = 0;
    int bi = 0;
    int c = 0;
    int drain = 0;
    bit a_acc;
    bit b_acc;
    timed_out = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    while (drain < 4) begin
      if (c >= LOGLEN) begin
        timed_out = 1'b1;
        break;
      end
      if (!a_valid && ai < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        a_valid = 1'b1;
        a_data  = W'(src_a[ai]);
      end
      if (!b_valid && bi < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        b_valid = 1'b1;
        b_data  = W'(src_b[bi]);
      end
      if (rnd) sum_ready = ($urandom_range(0, 2) != 0);
      else     sum_ready = !(c >= stall_lo && c <= stall_hi);
      @(negedge clk);
      a_acc = a_valid && a_ready;
      b_acc = b_valid && b_ready;
      log_sv[c] = sum_valid;
      log_sd[c] = sum_data;
      log_ar[c] = a_ready;
      log_br[c] = b_ready;
      @(posedge clk);
      #1;
      if (a_acc) begin a_valid = 1'b0; ai++; end
      if (b_acc) begin b_valid = 1'b0; bi++; end
      if (ai == n && bi == n && out_q.size() >= n) drain++;
      c++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    sum_ready = 1'b1;
    cycles = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; sum_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_during: a_ready=%b b_ready=%b sum_valid=%b, want 1 1 0",
               a_ready, b_ready, sum_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1 || sum_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle c%0d: a_ready=%b b_ready=%b sum_valid=%b, want 1 1 0",
                 c, a_ready, b_ready, sum_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  // A=3 at cycle 0, B=5 at cycle 3: A back-pressured until the pair fires.
  task automatic test_imbalance();
    for (int c = 0; c < 8; c++) begin
      a_valid = (c == 0); a_data = 8'd3;
      b_valid = (c == 3); b_data = 8'd5;
      sum_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (a_ready !== ((c >= 1 && c <= 3) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL imbalance_a_ready c%0d: got %b, want %b", c, a_ready,
                 (c >= 1 && c <= 3) ? 1'b0 : 1'b1);
      end
      checks++;
      if (sum_valid !== (c == 5)) begin
        errors++;
        $display("FAIL imbalance_sum_valid c%0d: got %b, want %b", c, sum_valid, (c == 5));
      end
      if (c == 5) begin
        checks++;
        if (sum_data !== 9'd8) begin
          errors++;
          $display("FAIL imbalance_sum_data: got %0d, want 8", sum_data);
        end
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  // Widest and smallest operands: carry must appear in bit W.
  task automatic test_extremes();
    logic [W:0] exp_sum [0:1];
    exp_sum[0] = 9'd255 + 9'd255;
    exp_sum[1] = 9'd0;
    for (int c = 0; c < 5; c++) begin
      a_valid = (c < 2); b_valid = (c < 2);
      a_data = (c == 0) ? 8'hFF : 8'h00;
      b_data = (c == 0) ? 8'hFF : 8'h00;
      sum_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (sum_valid !== (c == 2 || c == 3)) begin
        errors++;
        $display("FAIL extremes_valid c%0d: got %b, want %b", c, sum_valid, (c == 2 || c == 3));
      end else if (sum_valid) begin
        checks++;
        if (sum_data !== exp_sum[c-2]) begin
          errors++;
          $display("FAIL extremes_data c%0d: got %0d, want %0d", c, sum_data, exp_sum[c-2]);
        end
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  // a_k=k, b_k=2k continuously: one sum 3k per clock, two cycles after input.
  task automatic test_back_to_back();
    int cycles;
    bit to;
    for (int k = 0; k < 16; k++) begin src_a[k] = k; src_b[k] = 2 * k; end
    clear_queues();
    run_stream(16, 1'b0, -1, -1, cycles, to);
    checks++;
    if (to) begin errors++; $display("FAIL b2b_timeout: cycles=%0d", cycles); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (log_ar[k] !== 1'b1 || log_br[k] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready c%0d: a_ready=%b b_ready=%b, want 1 1", k, log_ar[k], log_br[k]);
      end
      checks++;
      if (log_sv[k+2] !== 1'b1 || log_sd[k+2] !== 9'(3 * k)) begin
        errors++;
        $display("FAIL b2b_sum k%0d: valid=%b data=%0d, want 1 %0d", k, log_sv[k+2], log_sd[k+2], 3 * k);
      end
    end
    checks++;
    if (log_sv[18] !== 1'b0 || log_sv[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_edges: valid c1=%b c18=%b, want 0 0", log_sv[1], log_sv[18]);
    end
  endtask

  // Same stream with sum_ready low for cycles 6..10.
  task automatic test_stall();
    int cycles;
    bit to;
    bit saw_low;
    bit held_low;
    for (int k = 0; k < 16; k++) begin src_a[k] = k; src_b[k] = 2 * k; end
    clear_queues();
    run_stream(16, 1'b0, 6, 10, cycles, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: cycles=%0d", cycles); end
    for (int c = 7; c <= 10; c++) begin
      checks++;
      if (log_sv[c] !== 1'b1 || log_sd[c] !== log_sd[6]) begin
        errors++;
        $display("FAIL stall_hold c%0d: valid=%b data=%0d, want 1 %0d", c, log_sv[c], log_sd[c], log_sd[6]);
      end
    end
    saw_low = 1'b0;
    for (int c = 6; c <= 10; c++) if (!log_ar[c] && !log_br[c]) saw_low = 1'b1;
    checks++;
    if (!saw_low) begin errors++; $display("FAIL stall_backpressure: ready never dropped, want 0"); end
    // Once the registered ready has fallen the buffer is full, so the holds
    // must keep both inputs back-pressured for the rest of the stall.
    held_low = 1'b1;
    for (int c = 7; c <= 10; c++) if (log_ar[c] !== 1'b0 || log_br[c] !== 1'b0) held_low = 1'b0;
    checks++;
    if (!held_low) begin
      errors++;
      $display("FAIL stall_absorb: inputs accepted during cycles 7-10, want ready 0");
    end
    checks++;
    if (out_q.size() !== 16) begin
      errors++;
      $display("FAIL stall_count: got %0d sums, want 16", out_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (out_q[k] !== 9'(3 * k)) begin
          errors++;
          $display("FAIL stall_order k%0d: got %0d, want %0d", k, out_q[k], 3 * k);
        end
      end
    end
    for (int c = 11; c < cycles && c < 30; c++) begin
      if (log_sv[c-1] && !log_sv[c] && (c - 11) < 16 - 6) begin
        errors++;
        $display("FAIL stall_bubble c%0d: valid=0, want 1", c);
      end
    end
  endtask

  // Holds full and buffer full, then a 1-cycle reset pulse.
  task automatic test_reset_mid();
    int nvalid;
    for (int c = 0; c < 5; c++) begin
      a_valid = 1'b1; a_data = 8'd1;
      b_valid = 1'b1; b_data = 8'd1;
      sum_ready = (c < 2);
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (sum_valid !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
          errors++;
          $display("FAIL midrst_setup: sum_valid=%b a_ready=%b b_ready=%b, want 1 0 0",
                   sum_valid, a_ready, b_ready);
        end
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #2;
    checks++;
    if (sum_valid !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: sum_valid=%b a_ready=%b b_ready=%b, want 0 1 1",
               sum_valid, a_ready, b_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      a_valid = (c == 0); a_data = 8'd7;
      b_valid = (c == 0); b_data = 8'd9;
      sum_ready = 1'b1;
      @(negedge clk);
      if (sum_valid === 1'b1) begin
        nvalid++;
        checks++;
        if (sum_data !== 9'd16) begin
          errors++;
          $display("FAIL midrst_data c%0d: got %0d, want 16", c, sum_data);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nvalid != 1) begin
      errors++;
      $display("FAIL midrst_count: got %0d sums, want 1", nvalid);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  // Random valids, ready and data; model pairs accepted operands by index.
  task automatic test_random();
    int cycles;
    bit to;
    int n = 40;
    for (int k = 0; k < n; k++) begin
      src_a[k] = $urandom_range(0, 255);
      src_b[k] = $urandom_range(0, 255);
    end
    clear_queues();
    run_stream(n, 1'b1, -1, -1, cycles, to);
    checks++;
    if (to) begin errors++; $display("FAIL random_timeout: cycles=%0d", cycles); end
    checks++;
    if (acc_a_q.size() != n || acc_b_q.size() != n || out_q.size() != n) begin
      errors++;
      $display("FAIL random_count: a=%0d b=%0d sums=%0d, want %0d each",
               acc_a_q.size(), acc_b_q.size(), out_q.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (out_q[k] !== 9'(src_a[k] + src_b[k]) || acc_a_q[k] != src_a[k] || acc_b_q[k] != src_b[k]) begin
          errors++;
          $display("FAIL random_sum k%0d: got %0d, want %0d", k, out_q[k], src_a[k] + src_b[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_imbalance();
    test_extremes();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
